// File: rtl/hsem_task_dispatch.sv
// Task dispatcher fed by the semaphore task-status vector: rising bits become
// pending tasks, which are offered round-robin to the core and tracked until done or timeout.
module hsem_task_dispatch #(
    parameter int unsigned TASK_W    = 32,
    parameter int unsigned ID_W      = 5,
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [TASK_W-1:0] tsk_stat,
    input  logic              disp_en,
    output logic              task_valid,
    output logic [ID_W-1:0]   task_id,
    input  logic              task_ack,
    input  logic              task_done,
    output logic              busy,
    output logic [TASK_W-1:0] pend,
    output logic              timeout_irq
);

    localparam int unsigned CNT_W = (TO_CYCLES == 0) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = (TO_CYCLES == 0) ? '0 : CNT_W'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TASK_W-1:0] tsk_q;
    logic [TASK_W-1:0] pending;
    logic [TASK_W-1:0] rise;
    logic [TASK_W-1:0] clr;
    logic [ID_W-1:0]   last_ptr;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   scan_idx;
    logic              found;
    logic [CNT_W-1:0]  cnt;
    logic              offer_take;
    logic              run_timeout;

    assign rise        = tsk_stat & ~tsk_q;
    assign offer_take  = (state == ST_OFFER) && task_ack;
    assign clr         = offer_take ? (TASK_W'(1) << task_id) : '0;
    assign run_timeout = (TO_CYCLES != 0) && (cnt == CNT_TERM);
    assign pend        = pending;

    // Round-robin: first pending slot after last_ptr, wrapping past the top.
    always_comb begin
        pick     = last_ptr;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= TASK_W; i++) begin
            scan_idx = ID_W'((32'(last_ptr) + i) % TASK_W);
            if (!found && pending[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (disp_en && (|pending)) state_nxt = ST_OFFER;
            end
            ST_OFFER: begin
                if (task_ack)      state_nxt = ST_RUN;
                else if (!disp_en) state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (task_done)        state_nxt = ST_IDLE;
                else if (run_timeout) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        task_valid = (state == ST_OFFER);
        busy       = (state == ST_RUN);
    end

    // Set wins over clear, so a bit re-rising on its ack cycle stays pending.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            tsk_q       <= '0;
            pending     <= '0;
            task_id     <= '0;
            last_ptr    <= ID_W'(TASK_W - 1);
            cnt         <= '0;
            timeout_irq <= 1'b0;
        end else begin
            tsk_q   <= tsk_stat;
            pending <= (pending & ~clr) | rise;
            if ((state == ST_IDLE) && (state_nxt == ST_OFFER)) task_id <= pick;
            if (offer_take) begin
                last_ptr <= task_id;
                cnt      <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
            timeout_irq <= (state == ST_RUN) && !task_done && run_timeout;
        end
    end

endmodule
